// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the branch/PC unit: control-transfer encodings,
// fetch FSM state codes and reset defaults.
package branch_pc_unit_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BGEZ = 3'd3,
      BR_BLTZ = 3'd4,
      BR_J    = 3'd5,
      BR_JAL  = 3'd6,
      BR_JR   = 3'd7
   } br_type_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } pc_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;
   localparam logic [31:0] LINK_OFFSET      = 32'd8;

   // Word offset to byte offset, sign-extended to 32 bits.
   function automatic logic [31:0] sext_word_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode/fetch signal bundle between the pipeline and the branch/PC unit.
interface branch_pc_unit_if;
   logic        stall;
   logic        fetch_wait;
   logic        D_valid;
   logic [31:0] D_pc;
   logic [2:0]  br_type;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] ra_data;
   logic        equal;
   logic        gtzero;
   logic [31:0] F_pc;
   logic        D_taken;
   logic [31:0] link_pc;
   logic [31:0] br_count;
   logic [31:0] taken_count;

   modport master (
      output stall, fetch_wait, D_valid, D_pc, br_type, imm16, instr_index,
             ra_data, equal, gtzero,
      input  F_pc, D_taken, link_pc, br_count, taken_count
   );

   modport slave (
      input  stall, fetch_wait, D_valid, D_pc, br_type, imm16, instr_index,
             ra_data, equal, gtzero,
      output F_pc, D_taken, link_pc, br_count, taken_count
   );
endinterface

// File: rtl/branch_pc_unit_branch_target.sv
// Combinational taken decision and target address for the decode-stage
// control transfer.
module branch_target
   import branch_pc_unit_pkg::*;
(
   input  logic [31:0] d_pc,
   input  logic [2:0]  br_type,
   input  logic [15:0] imm16,
   input  logic [25:0] instr_index,
   input  logic [31:0] ra_data,
   input  logic        equal,
   input  logic        gtzero,
   output logic        taken,
   output logic [31:0] target
);

   logic [31:0] pc_plus4;
   logic [31:0] branch_addr;
   logic [31:0] jump_addr;

   assign pc_plus4    = d_pc + INSTR_BYTES;
   assign branch_addr = pc_plus4 + sext_word_offset(imm16);
   assign jump_addr   = {pc_plus4[31:28], instr_index, 2'b00};

   always_comb begin
      taken  = 1'b0;
      target = branch_addr;
      case (br_type_e'(br_type))
         BR_BEQ:  taken = equal;
         BR_BNE:  taken = ~equal;
         BR_BGEZ: taken = gtzero;
         BR_BLTZ: taken = ~gtzero;
         BR_J, BR_JAL: begin
            taken  = 1'b1;
            target = jump_addr;
         end
         BR_JR: begin
            taken  = 1'b1;
            target = ra_data;
         end
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC sequencer: redirects on taken decode-stage transfers, parks a
// redirect while instruction memory is busy, and counts resolved transfers.
module branch_pc_unit
   import branch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   branch_pc_unit_if.slave   bus
);

   pc_state_e   state_reg, state_next;
   logic [31:0] f_pc_reg, f_pc_next;
   logic [31:0] pend_target_reg, pend_target_next;

   logic        resolve;
   logic        raw_taken;
   logic        d_taken;
   logic [31:0] target;
   logic [1:0]  cnt_inc;

   branch_target u_branch_target (
      .d_pc        (bus.D_pc),
      .br_type     (bus.br_type),
      .imm16       (bus.imm16),
      .instr_index (bus.instr_index),
      .ra_data     (bus.ra_data),
      .equal       (bus.equal),
      .gtzero      (bus.gtzero),
      .taken       (raw_taken),
      .target      (target)
   );

   assign resolve = bus.D_valid & ~bus.stall;
   assign d_taken = resolve & raw_taken;

   assign bus.D_taken = d_taken;
   assign bus.link_pc = bus.D_pc + LINK_OFFSET;
   assign bus.F_pc    = f_pc_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_RUN;
         f_pc_reg        <= RESET_PC;
         pend_target_reg <= '0;
      end else begin
         state_reg       <= state_next;
         f_pc_reg        <= f_pc_next;
         pend_target_reg <= pend_target_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      f_pc_next        = f_pc_reg;
      pend_target_next = pend_target_reg;
      case (state_reg)
         ST_RUN: begin
            if (!bus.stall) begin
               if (!bus.fetch_wait) begin
                  f_pc_next = d_taken ? target : f_pc_reg + PC_STEP;
               end else if (d_taken) begin
                  pend_target_next = target;
                  state_next       = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            // A taken transfer seen here sits in the delay slot of the
            // parked redirect and must not replace it.
            if (!bus.stall && !bus.fetch_wait) begin
               f_pc_next  = pend_target_reg;
               state_next = ST_RUN;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   assign cnt_inc[0] = resolve && (br_type_e'(bus.br_type) != BR_NONE);
   assign cnt_inc[1] = d_taken;

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_reg <= '0;
         end else if (cnt_inc[gi]) begin
            cnt_reg <= cnt_reg + 32'd1;
         end
      end
   end

   assign bus.br_count    = g_cnt[0].cnt_reg;
   assign bus.taken_count = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: sequential fetch, branch/jump
// redirects, parked redirects under fetch_wait, stall and reset.
module tb_branch_pc_unit;
   import branch_pc_unit_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   branch_pc_unit_if bus();

   branch_pc_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic show(input string what);
      $display("%s: F_pc=%08h D_taken=%0b br_count=%0d taken_count=%0d",
               what, bus.F_pc, bus.D_taken, bus.br_count, bus.taken_count);
   endtask

   task automatic idle_decode();
      bus.D_valid     = 1'b0;
      bus.br_type     = BR_NONE;
      bus.D_pc        = '0;
      bus.imm16       = '0;
      bus.instr_index = '0;
      bus.ra_data     = '0;
      bus.equal       = 1'b0;
      bus.gtzero      = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      bus.stall      = 1'b0;
      bus.fetch_wait = 1'b0;
      idle_decode();

      // Reset and free-running fetch
      step(); show("reset");
      chk("reset_pc", bus.F_pc, 32'h0000_3000);
      chk("reset_brc", bus.br_count, 32'd0);
      chk("reset_tkc", bus.taken_count, 32'd0);
      reset = 1'b0;
      step(); show("seq1"); chk("seq1_pc", bus.F_pc, 32'h0000_3004);
      step(); show("seq2"); chk("seq2_pc", bus.F_pc, 32'h0000_3008);
      step(); show("seq3"); chk("seq3_pc", bus.F_pc, 32'h0000_300C);
      chk("seq3_brc", bus.br_count, 32'd0);
      chk("seq3_tkc", bus.taken_count, 32'd0);

      // BEQ taken backwards: 0x3014 - 16 = 0x3004
      bus.D_valid = 1'b1; bus.br_type = BR_BEQ; bus.D_pc = 32'h0000_3010;
      bus.imm16 = 16'hFFFC; bus.equal = 1'b1;
      #1;
      chk("beq_taken", {31'd0, bus.D_taken}, 32'd1);
      chk("beq_link", bus.link_pc, 32'h0000_3018);
      step(); show("beq");
      chk("beq_pc", bus.F_pc, 32'h0000_3004);
      chk("beq_brc", bus.br_count, 32'd1);
      chk("beq_tkc", bus.taken_count, 32'd1);

      // BLTZ not taken (gtzero=1)
      bus.br_type = BR_BLTZ; bus.D_pc = 32'h0000_3004; bus.gtzero = 1'b1;
      bus.equal = 1'b0;
      #1;
      chk("bltz_taken", {31'd0, bus.D_taken}, 32'd0);
      step(); show("bltz");
      chk("bltz_pc", bus.F_pc, 32'h0000_3008);
      chk("bltz_brc", bus.br_count, 32'd2);
      chk("bltz_tkc", bus.taken_count, 32'd1);

      // J keeps the upper nibble of D_pc+4 (0x7FFFFFFC+4 = 0x80000000)
      bus.br_type = BR_J; bus.D_pc = 32'h7FFF_FFFC; bus.instr_index = 26'h000_0C40;
      #1;
      chk("j_taken", {31'd0, bus.D_taken}, 32'd1);
      step(); show("j");
      chk("j_pc", bus.F_pc, 32'h8000_3100);

      // BGEZ target wraps past 2^32: 0xFFFFFFFC + 4 = 0
      bus.br_type = BR_BGEZ; bus.D_pc = 32'hFFFF_FFF8; bus.imm16 = 16'h0001;
      bus.gtzero = 1'b1;
      step(); show("bgez_wrap");
      chk("bgez_wrap_pc", bus.F_pc, 32'h0000_0000);
      chk("bgez_brc", bus.br_count, 32'd4);
      chk("bgez_tkc", bus.taken_count, 32'd3);

      // JR while instruction memory waits 3 cycles
      bus.br_type = BR_JR; bus.ra_data = 32'h0000_4000; bus.D_pc = 32'h0000_0000;
      bus.fetch_wait = 1'b1;
      #1;
      chk("jr_taken", {31'd0, bus.D_taken}, 32'd1);
      step(); show("jr_wait1");
      chk("jr_wait1_pc", bus.F_pc, 32'h0000_0000);
      chk("jr_tkc", bus.taken_count, 32'd4);
      idle_decode();
      step(); show("jr_wait2"); chk("jr_wait2_pc", bus.F_pc, 32'h0000_0000);
      step(); show("jr_wait3"); chk("jr_wait3_pc", bus.F_pc, 32'h0000_0000);
      bus.fetch_wait = 1'b0;
      step(); show("jr_go"); chk("jr_go_pc", bus.F_pc, 32'h0000_4000);
      step(); show("jr_next"); chk("jr_next_pc", bus.F_pc, 32'h0000_4004);

      // Delay-slot jump while PEND: counted, but the parked target wins
      bus.D_valid = 1'b1; bus.br_type = BR_JR; bus.ra_data = 32'h0000_4000;
      bus.fetch_wait = 1'b1;
      step(); show("pend_park"); chk("pend_park_pc", bus.F_pc, 32'h0000_4004);
      bus.br_type = BR_J; bus.D_pc = 32'h0000_4000; bus.instr_index = 26'h000_0800;
      bus.fetch_wait = 1'b0;
      step(); show("pend_slot");
      chk("pend_slot_pc", bus.F_pc, 32'h0000_4000);
      chk("pend_slot_brc", bus.br_count, 32'd7);
      chk("pend_slot_tkc", bus.taken_count, 32'd6);

      // Stall during a taken BNE: 0x4004 + 0x40 = 0x4044
      bus.br_type = BR_BNE; bus.D_pc = 32'h0000_4000; bus.imm16 = 16'h0010;
      bus.equal = 1'b0; bus.stall = 1'b1;
      #1;
      chk("bne_stall_taken", {31'd0, bus.D_taken}, 32'd0);
      step(); show("bne_stall1"); chk("bne_stall1_pc", bus.F_pc, 32'h0000_4000);
      step(); show("bne_stall2"); chk("bne_stall2_pc", bus.F_pc, 32'h0000_4000);
      chk("bne_stall_brc", bus.br_count, 32'd7);
      chk("bne_stall_tkc", bus.taken_count, 32'd6);
      bus.stall = 1'b0;
      step(); show("bne_go");
      chk("bne_go_pc", bus.F_pc, 32'h0000_4044);
      chk("bne_go_brc", bus.br_count, 32'd8);
      chk("bne_go_tkc", bus.taken_count, 32'd7);
      idle_decode();
      step(); show("bne_after"); chk("bne_after_pc", bus.F_pc, 32'h0000_4048);

      // Reset while PEND discards the parked target
      bus.D_valid = 1'b1; bus.br_type = BR_JR; bus.ra_data = 32'h0000_5000;
      bus.fetch_wait = 1'b1;
      step(); show("rst_park"); chk("rst_park_pc", bus.F_pc, 32'h0000_4048);
      idle_decode();
      reset = 1'b1;
      step(); show("rst_pend");
      chk("rst_pend_pc", bus.F_pc, 32'h0000_3000);
      chk("rst_pend_brc", bus.br_count, 32'd0);
      chk("rst_pend_tkc", bus.taken_count, 32'd0);
      reset = 1'b0; bus.fetch_wait = 1'b0;
      step(); show("rst_run1"); chk("rst_run1_pc", bus.F_pc, 32'h0000_3004);
      step(); show("rst_run2"); chk("rst_run2_pc", bus.F_pc, 32'h0000_3008);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_3000, fetch address loaded on reset.
REQ-002 Parameter: PC_STEP, 32'd4, sequential fetch increment.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high.
REQ-005 Port: stall  in  1  decode hazard stall; D and F both freeze.
REQ-006 Port: fetch_wait  in  1  instruction memory not ready; F_pc must hold.
REQ-007 Port: D_valid  in  1  decode-stage instruction is valid.
REQ-008 Port: D_pc  in  32  PC of the decode-stage instruction.
REQ-009 Port: br_type  in  3  NONE/BEQ/BNE/BGEZ/BLTZ/J/JAL/JR encoding.
REQ-010 Port: imm16  in  16  branch offset, in words.
REQ-011 Port: instr_index  in  26  jump index.
REQ-012 Port: ra_data  in  32  forwarded rs value for JR.
REQ-013 Port: equal  in  1  from comparator; D1==D2.
REQ-014 Port: gtzero  in  1  from comparator; D1 sign bit clear (D1>=0).
REQ-015 Port: F_pc  out  32  current fetch address, registered.
REQ-016 Port: D_taken  out  1  combinational; decode branch/jump resolves taken this cycle.
REQ-017 Port: link_pc  out  32  D_pc+8, for JAL write-back.
REQ-018 Port: br_count  out  32  resolved control-transfer count.
REQ-019 Port: taken_count  out  32  taken control-transfer count.

Function
REQ-020 Resolve event SHALL be D_valid & ~stall; D_taken SHALL be 0 outside a resolve event.
REQ-021 Taken SHALL be: BEQ equal; BNE ~equal; BGEZ gtzero; BLTZ ~gtzero; J/JAL/JR 1; NONE 0.
REQ-022 Branch target SHALL be D_pc+4+(sign-extended imm16 shifted left 2), modulo 2^32; wrap is silent.
REQ-023 J/JAL target SHALL be {(D_pc+4)[31:28], instr_index, 2'b00}; JR target SHALL be ra_data unmodified, with no alignment check.
REQ-024 FSM states SHALL be RUN and PEND, with a 32-bit pend_target register.
REQ-025 In RUN, when stall=0 and fetch_wait=0: F_pc <= taken resolve ? target : F_pc+PC_STEP; latency one cycle.
REQ-026 In RUN, when stall=1: F_pc SHALL hold and no state change SHALL occur.
REQ-027 In RUN, when stall=0, fetch_wait=1 and a taken resolve occurs: F_pc SHALL hold, pend_target <= target, next state PEND.
REQ-028 In RUN, when stall=0, fetch_wait=1 and no taken resolve occurs: F_pc SHALL hold.
REQ-029 In PEND: F_pc SHALL hold while stall|fetch_wait; when both are 0, F_pc <= pend_target and next state RUN.
REQ-030 In PEND, a taken resolve (delay-slot branch) SHALL NOT change pend_target or F_pc, but SHALL be counted.
REQ-031 br_count SHALL increment on each resolve event with br_type!=NONE; taken_count SHALL increment on each taken resolve; both wrap at 2^32.
REQ-032 link_pc SHALL be combinational D_pc+8 and independent of state.

Reset
REQ-033 When reset=1 at a clk edge: F_pc=RESET_PC, state=RUN, pend_target=0, br_count=0, taken_count=0; reset overrides stall, fetch_wait and any resolve.
REQ-034 Reset asserted while in PEND SHALL discard the pending target.

Structure
REQ-035 Shared package SHALL hold the br_type encodings, the RUN/PEND state codes, and the RESET_PC default.
REQ-036 Target and taken logic SHALL be one combinational sub-module, branch_target; the FSM, F_pc register and counters SHALL sit in the top module.

Verification
REQ-037 Reset, then 3 free cycles -> F_pc 0x3000, 0x3004, 0x3008, 0x300C; both counters 0.
REQ-038 BEQ, D_pc=0x3010, imm16=0xFFFC, equal=1 -> D_taken=1, next F_pc=0x3004, br_count=1, taken_count=1.
REQ-039 BLTZ with gtzero=1 -> D_taken=0, F_pc+4, br_count increments, taken_count does not.
REQ-040 JR with ra_data=0x0000_4000 while fetch_wait=1 for 3 cycles -> PEND, F_pc held, then 0x4000 on the first cycle with fetch_wait=0.
REQ-041 stall=1 during a taken BNE -> F_pc held and counters unchanged; on release -> redirect applied once.
REQ-042 Reset asserted in PEND -> F_pc=0x3000, state RUN, pending target never fetched.
